// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port 1024x32 memory.
// Requester A (instruction fetch) only reads; requester B (load/store) reads
// or writes. Each access takes one IDLE cycle plus one ACC cycle, and ties
// are broken round-robin against the last granted requester.
module mem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        aReq,
   input  logic [9:0]  aAddr,
   output logic [31:0] aRdata,
   output logic        aAck,
   input  logic        bReq,
   input  logic        bWE,
   input  logic [9:0]  bAddr,
   input  logic [31:0] bWdata,
   output logic [31:0] bRdata,
   output logic        bAck,
   output logic        memWE,
   output logic [9:0]  memAddr,
   output logic [31:0] memDataIn,
   input  logic [31:0] memDataOut,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC_A = 2'd1,
      ACC_B = 2'd2
   } state_t;

   state_t      state_r;
   logic        last_b_r;   // 1 when B was granted most recently
   logic [9:0]  addr_r;     // address latched on grant
   logic [31:0] wdata_r;    // B store data latched on grant
   logic        we_r;       // B write enable latched on grant
   logic [31:0] acap_r;     // A read data captured at end of ACC_A
   logic [31:0] bcap_r;     // B read data captured at end of ACC_B
   logic        aack_r;
   logic        back_r;
   logic        busy_r;
   logic        wr_r;       // registered store strobe, high only in ACC_B of a store

   // Arbitration FSM: grants, latches the winner's request, captures read data
   // and registers every status output so acks and write strobe are glitch-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         last_b_r <= 1'b1;
         addr_r   <= 10'd0;
         wdata_r  <= 32'd0;
         we_r     <= 1'b0;
         acap_r   <= 32'd0;
         bcap_r   <= 32'd0;
         aack_r   <= 1'b0;
         back_r   <= 1'b0;
         busy_r   <= 1'b0;
         wr_r     <= 1'b0;
      end else begin
         aack_r <= 1'b0;
         back_r <= 1'b0;
         busy_r <= 1'b0;
         wr_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (aReq && (!bReq || last_b_r)) begin
                  state_r  <= ACC_A;
                  addr_r   <= aAddr;
                  last_b_r <= 1'b0;
                  aack_r   <= 1'b1;
                  busy_r   <= 1'b1;
               end else if (bReq) begin
                  state_r  <= ACC_B;
                  addr_r   <= bAddr;
                  wdata_r  <= bWdata;
                  we_r     <= bWE;
                  last_b_r <= 1'b1;
                  back_r   <= 1'b1;
                  busy_r   <= 1'b1;
                  wr_r     <= bWE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ACC_A: begin
               acap_r  <= memDataOut;
               state_r <= IDLE;
            end
            ACC_B: begin
               // memDataOut still shows the pre-write contents for a store
               bcap_r  <= memDataOut;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // A reset arriving mid-store must block the write in that same cycle.
   assign memWE     = wr_r & ~reset;
   assign memAddr   = addr_r;
   assign memDataIn = wdata_r;
   assign aAck      = aack_r;
   assign bAck      = back_r;
   assign busy      = busy_r;
   assign aRdata    = aack_r ? memDataOut : acap_r;
   assign bRdata    = back_r ? memDataOut : bcap_r;

   // we_r is kept as the latched copy of bWE; the store strobe is its
   // registered companion, so tie it into the write-data path check.
   logic unused_we_s;
   assign unused_we_s = we_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter with directed and random traffic against
// a memory model, and predicts every output from a transaction-level model
// (who owns the current cycle, what was latched, shadow memory contents).
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        aReq;
   logic [9:0]  aAddr;
   logic [31:0] aRdata;
   logic        aAck;
   logic        bReq;
   logic        bWE;
   logic [9:0]  bAddr;
   logic [31:0] bWdata;
   logic [31:0] bRdata;
   logic        bAck;
   logic        memWE;
   logic [9:0]  memAddr;
   logic [31:0] memDataIn;
   logic [31:0] memDataOut;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   // environment memory plus a backdoor port for preloading
   logic [31:0] env_mem [0:1023];
   logic        bd_we;
   logic [9:0]  bd_addr;
   logic [31:0] bd_data;

   // transaction model state
   logic [31:0] shadow [0:1023];
   int          m_owner;   // 0 none, 1 A, 2 B in the current cycle
   logic        m_lastb;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic        m_we;
   logic [31:0] m_acap;
   logic [31:0] m_bcap;

   mem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .aReq       (aReq),
      .aAddr      (aAddr),
      .aRdata     (aRdata),
      .aAck       (aAck),
      .bReq       (bReq),
      .bWE        (bWE),
      .bAddr      (bAddr),
      .bWdata     (bWdata),
      .bRdata     (bRdata),
      .bAck       (bAck),
      .memWE      (memWE),
      .memAddr    (memAddr),
      .memDataIn  (memDataIn),
      .memDataOut (memDataOut),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign memDataOut = env_mem[memAddr];

   // memory write port: DUT writes, otherwise the backdoor preload
   always @(posedge clk) begin
      if (memWE) env_mem[memAddr] <= memDataIn;
      else if (bd_we) env_mem[bd_addr] <= bd_data;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [31:0] ea;
      logic [31:0] eb;
      ea = (m_owner == 1) ? shadow[m_addr] : m_acap;
      eb = (m_owner == 2) ? shadow[m_addr] : m_bcap;
      cmp("aAck",      {31'd0, aAck},  {31'd0, m_owner == 1});
      cmp("bAck",      {31'd0, bAck},  {31'd0, m_owner == 2});
      cmp("busy",      {31'd0, busy},  {31'd0, m_owner != 0});
      cmp("memWE",     {31'd0, memWE}, {31'd0, (m_owner == 2) && m_we && !reset});
      cmp("memAddr",   {22'd0, memAddr}, {22'd0, m_addr});
      cmp("memDataIn", memDataIn, m_wdata);
      cmp("aRdata",    aRdata, ea);
      cmp("bRdata",    bRdata, eb);
   endtask

   // advance the model by one clock using the inputs presented this cycle
   task automatic model_next();
      if (reset) begin
         m_owner = 0;
         m_lastb = 1'b1;
         m_addr  = 10'd0;
         m_wdata = 32'd0;
         m_we    = 1'b0;
         m_acap  = 32'd0;
         m_bcap  = 32'd0;
      end else if (m_owner == 1) begin
         m_acap  = shadow[m_addr];
         m_owner = 0;
      end else if (m_owner == 2) begin
         m_bcap = shadow[m_addr];
         if (m_we) shadow[m_addr] = m_wdata;
         m_owner = 0;
      end else if (aReq && (!bReq || m_lastb)) begin
         m_owner = 1;
         m_addr  = aAddr;
         m_lastb = 1'b0;
      end else if (bReq) begin
         m_owner = 2;
         m_addr  = bAddr;
         m_wdata = bWdata;
         m_we    = bWE;
         m_lastb = 1'b1;
      end
      if (bd_we) shadow[bd_addr] = bd_data;
   endtask

   // inputs are already set for this cycle: check, advance model, step clock
   task automatic tick();
      #1;
      check_all();
      model_next();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; aReq = 1'b0; aAddr = 10'd0; bReq = 1'b0; bWE = 1'b0;
      bAddr = 10'd0; bWdata = 32'd0; bd_we = 1'b0; bd_addr = 10'd0; bd_data = 32'd0;
      m_owner = 0; m_lastb = 1'b1; m_addr = 10'd0; m_wdata = 32'd0; m_we = 1'b0;
      m_acap = 32'd0; m_bcap = 32'd0;
      @(negedge clk);
      // first cycle under reset; DUT state is unknown until the first edge
      #1; model_next(); @(posedge clk); @(negedge clk);

      // preload memory while held in reset
      for (int i = 0; i < 1024; i++) begin
         bd_we   = 1'b1;
         bd_addr = 10'(i);
         bd_data = (i == 5) ? 32'hDEADBEEF : $urandom;
         tick();
      end
      bd_we = 1'b0;
      #1;
      cmp("rst_busy",    {31'd0, busy}, 32'd0);
      cmp("rst_memAddr", {22'd0, memAddr}, 32'd0);
      cmp("rst_aRdata",  aRdata, 32'd0);

      // A read of address 5
      reset = 1'b0; aReq = 1'b1; aAddr = 10'h005;
      #1; cmp("a_c1_aAck", {31'd0, aAck}, 32'd0);
      tick();
      aReq = 1'b0;
      #1;
      cmp("a_c2_aAck",    {31'd0, aAck}, 32'd1);
      cmp("a_c2_memAddr", {22'd0, memAddr}, 32'h0000_0005);
      cmp("a_c2_aRdata",  aRdata, 32'hDEADBEEF);
      tick();
      #1;
      cmp("a_c3_aAck",   {31'd0, aAck}, 32'd0);
      cmp("a_c3_aRdata", aRdata, 32'hDEADBEEF);
      tick();

      // B store to 3FF, then B load back
      bReq = 1'b1; bWE = 1'b1; bAddr = 10'h3FF; bWdata = 32'h12345678;
      #1; cmp("st_idle_memWE", {31'd0, memWE}, 32'd0);
      tick();
      bReq = 1'b0;
      #1;
      cmp("st_memWE",   {31'd0, memWE}, 32'd1);
      cmp("st_memAddr", {22'd0, memAddr}, 32'h0000_03FF);
      cmp("st_bAck",    {31'd0, bAck}, 32'd1);
      tick();
      #1; cmp("st_after_memWE", {31'd0, memWE}, 32'd0);
      bReq = 1'b1; bWE = 1'b0; bAddr = 10'h3FF;
      tick();
      bReq = 1'b0;
      #1; cmp("ld_bRdata", bRdata, 32'h12345678);
      tick();

      // both requesters held high from reset release
      reset = 1'b1;
      tick();
      reset = 1'b0; aReq = 1'b1; bReq = 1'b1; bWE = 1'b0; aAddr = 10'h001; bAddr = 10'h002;
      for (int c = 1; c <= 8; c++) begin
         #1;
         cmp("rr_aAck", {31'd0, aAck}, {31'd0, (c % 4) == 2});
         cmp("rr_bAck", {31'd0, bAck}, {31'd0, (c % 4) == 0});
         tick();
      end

      // B address change during ACC_B is ignored
      aReq = 1'b0; bReq = 1'b1; bAddr = 10'h001;
      tick();
      bAddr = 10'h002;
      #1; cmp("hold_memAddr", {22'd0, memAddr}, 32'h0000_0001);
      tick();
      bReq = 1'b0;
      tick();

      // reset during a store to 0x010 blocks the write
      bd_we = 1'b1; bd_addr = 10'h010; bd_data = 32'hA5A50016;
      tick();
      bd_we = 1'b0;
      bReq = 1'b1; bWE = 1'b1; bAddr = 10'h010; bWdata = 32'hFFFF0000;
      tick();
      reset = 1'b1;
      #1; cmp("rstwr_memWE", {31'd0, memWE}, 32'd0);
      tick();
      reset = 1'b0; bReq = 1'b0;
      #1;
      cmp("rstwr_busy",   {31'd0, busy}, 32'd0);
      cmp("rstwr_bAck",   {31'd0, bAck}, 32'd0);
      cmp("rstwr_memAddr", {22'd0, memAddr}, 32'd0);
      cmp("rstwr_memDin", memDataIn, 32'd0);
      cmp("rstwr_bRdata", bRdata, 32'd0);
      cmp("rstwr_mem16",  env_mem[16], 32'hA5A50016);
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         reset  = ($urandom_range(0, 63) == 0);
         aReq   = 1'($urandom_range(0, 1));
         bReq   = 1'($urandom_range(0, 1));
         bWE    = 1'($urandom_range(0, 1));
         aAddr  = 10'($urandom_range(0, 15));
         bAddr  = 10'($urandom_range(0, 15));
         bWdata = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; address width fixed at 10 bits, data width at 32 bits (1024 x 32 memory).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 aReq  input  1  requester A (instruction fetch) read request; held until aAck.
REQ-005 aAddr  input  10  requester A word address.
REQ-006 aRdata  output  32  requester A read data.
REQ-007 aAck  output  1  requester A access-complete strobe.
REQ-008 bReq  input  1  requester B (load/store) request; held until bAck.
REQ-009 bWE  input  1  requester B write enable (1 = store, 0 = load).
REQ-010 bAddr  input  10  requester B word address.
REQ-011 bWdata  input  32  requester B store data.
REQ-012 bRdata  output  32  requester B read data.
REQ-013 bAck  output  1  requester B access-complete strobe.
REQ-014 memWE  output  1  memory write enable.
REQ-015 memAddr  output  10  memory address.
REQ-016 memDataIn  output  32  memory write data.
REQ-017 memDataOut  input  32  memory read data (asynchronous read of memAddr).
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM SHALL have exactly three states: IDLE, ACC_A, ACC_B.
REQ-020 IDLE: neither req -> stay IDLE; only aReq -> ACC_A; only bReq -> ACC_B; both -> the requester not in lastGrant.
REQ-021 On entry to ACC_x: latch that requester's address (and, for B, bWE and bWdata) into internal registers; set lastGrant = x.
REQ-022 ACC_A and ACC_B SHALL last exactly one cycle, then return to IDLE unconditionally; one access costs 2 cycles; max throughput one access per 2 cycles.
REQ-023 memAddr/memDataIn SHALL drive the latched values in ACC_x; in IDLE they hold their last latched values.
REQ-024 memWE = (state == ACC_B) AND latched bWE AND NOT reset; memWE is never high in IDLE or ACC_A.
REQ-025 aAck high exactly during ACC_A, bAck high exactly during ACC_B; both decoded from registered state (glitch-free); never both high.
REQ-026 During ACC_x, xRdata = memDataOut; at the posedge ending ACC_x, memDataOut is captured; xRdata holds the captured value until the next ACC_x.
REQ-027 For a B store, bRdata SHALL capture memDataOut as seen during ACC_B (pre-write contents).
REQ-028 Requester input changes during ACC_x SHALL be ignored; a req dropped during ACC_x still completes with ack.
REQ-029 A requester keeping req high through its ack cycle is treated as a new request in the following IDLE cycle (round-robin applies).
REQ-030 Round robin: with both req continuously high, grants SHALL alternate A, B, A, B...; neither requester waits more than one other access.

Reset
REQ-031 When reset is high at a posedge: state = IDLE, lastGrant = B (A wins first tie), latched addr/data/bWE = 0, captured read data = 0.
REQ-032 After reset: aAck = bAck = memWE = busy = 0, memAddr = 0, memDataIn = 0, aRdata = bRdata = 0.
REQ-033 Reset asserted during ACC_B with a store SHALL suppress memWE in that cycle (no memory write); no ack credit survives reset.

Verification
REQ-034 Reset, then aReq=1, aAddr=10'h005, mem[5]=32'hDEADBEEF -> cycle 1 IDLE, cycle 2 ACC_A with memAddr=5, aAck=1, aRdata=32'hDEADBEEF; aRdata holds it afterwards.
REQ-035 bReq=1, bWE=1, bAddr=10'h3FF, bWdata=32'h12345678 -> memWE=1 only in ACC_B, memAddr=10'h3FF; a later B load of 10'h3FF returns 32'h12345678.
REQ-036 aReq and bReq held high from reset release for 8 cycles -> ACC_A, ACC_B, ACC_A, ACC_B at cycles 2, 4, 6, 8; aAck/bAck never overlap.
REQ-037 Change bAddr from 10'h001 to 10'h002 during ACC_B -> memAddr stays 10'h001 for the whole access.
REQ-038 Assert reset during ACC_B of a store to 10'h010 -> memWE=0 that cycle, mem[16] unchanged; next cycle IDLE, all outputs at reset values.
